// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: size codes, the sign bit,
// FSM state encodings and the size decode helper.
package data_mem_ctrl_pkg;

   localparam logic [2:0] SZ_BYTE  = 3'b001;
   localparam logic [2:0] SZ_HALF  = 3'b011;
   localparam logic [2:0] SZ_WORD  = 3'b111;
   localparam int         SIGN_BIT = 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      SIZE_B,
      SIZE_H,
      SIZE_W
   } size_e;

   // Any code that is not an explicit byte or half access behaves as a word.
   function automatic size_e decode_size(input logic [2:0] code);
      case (code)
         SZ_BYTE: return SIZE_B;
         SZ_HALF: return SIZE_H;
         default: return SIZE_W;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// CPU MEM-stage port of the data-memory controller; the CPU is the master.
interface data_mem_ctrl_if;

   logic [31:0] addr;
   logic [31:0] write_data;
   logic        memwrite;
   logic        memread;
   logic [3:0]  sign_mask;
   logic [31:0] read_data;
   logic        stall;
   logic        misaligned;

   modport master (
      output addr, write_data, memwrite, memread, sign_mask,
      input  read_data, stall, misaligned
   );

   modport slave (
      input  addr, write_data, memwrite, memread, sign_mask,
      output read_data, stall, misaligned
   );

endinterface

// File: rtl/data_mem_ctrl_byte_lane_unit.sv
// Combinational lane logic: load extraction with sign/zero extension, and the
// store merge of right-aligned data into the word read back from SRAM.
module data_mem_ctrl_byte_lane_unit
   import data_mem_ctrl_pkg::*;
(
   input  size_e       size_i,
   input  logic        sext_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
   assign half_sel = rdata_i[{lane_i[1], 4'b0000} +: 16];

   // NOTE: every output gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      load_o   = rdata_i;
      merged_o = rdata_i;
      case (size_i)
         SIZE_B: begin
            load_o = {{24{sext_i & byte_sel[7]}}, byte_sel};
            merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SIZE_H: begin
            load_o = {{16{sext_i & half_sel[15]}}, half_sel};
            merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         end
         default: begin
            load_o   = rdata_i;
            merged_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: CPU MEM-stage port to a 1-cycle-latency word SRAM,
// with read-modify-write stores, extended loads and a pipeline stall.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   data_mem_ctrl_if.slave        cpu,
   output logic [ADDR_WIDTH-1:0] sram_addr_o,
   output logic                  sram_ren_o,
   output logic                  sram_wen_o,
   output logic [31:0]           sram_wdata_o,
   input  logic [31:0]           sram_rdata_i
);

   logic [1:0]            state_q, state_d;
   logic [31:0]           read_data_q, read_data_d;
   logic [31:0]           merged_q, merged_d;
   logic                  misaligned_q, misaligned_d;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic [1:0]            lane_q;
   logic [31:0]           wdata_q;
   size_e                 size_q;
   logic                  sext_q;
   logic                  store_q;

   logic                  req;
   logic                  aligned;
   logic                  go;
   size_e                 size_req;
   logic [31:0]           load_word;
   logic [31:0]           merged_word;

   assign req      = cpu.memread | cpu.memwrite;
   assign size_req = decode_size(cpu.sign_mask[2:0]);

   always_comb begin
      case (size_req)
         SIZE_H:  aligned = ~cpu.addr[0];
         SIZE_W:  aligned = (cpu.addr[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
   end

   assign go = (state_q == ST_IDLE) & req & aligned;

   data_mem_ctrl_byte_lane_unit u_lane (
      .size_i   (size_q),
      .sext_i   (sext_q),
      .lane_i   (lane_q),
      .rdata_i  (sram_rdata_i),
      .wdata_i  (wdata_q),
      .load_o   (load_word),
      .merged_o (merged_word)
   );

   always_comb begin
      state_d      = state_q;
      read_data_d  = read_data_q;
      merged_d     = merged_q;
      misaligned_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (go)
               state_d = ST_RD;
            else if (req)
               misaligned_d = 1'b1;
         end
         ST_RD: begin
            if (store_q) begin
               merged_d = merged_word;
               state_d  = ST_WR;
            end else begin
               read_data_d = load_word;
               state_d     = ST_DONE;
            end
         end
         ST_WR:   state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         read_data_q  <= '0;
         merged_q     <= '0;
         misaligned_q <= 1'b0;
         waddr_q      <= '0;
         lane_q       <= '0;
         wdata_q      <= '0;
         size_q       <= SIZE_B;
         sext_q       <= 1'b0;
         store_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         read_data_q  <= read_data_d;
         merged_q     <= merged_d;
         misaligned_q <= misaligned_d;
         if (go) begin
            waddr_q <= cpu.addr[ADDR_WIDTH+1:2];
            lane_q  <= cpu.addr[1:0];
            wdata_q <= cpu.write_data;
            size_q  <= size_req;
            sext_q  <= cpu.sign_mask[SIGN_BIT];
            store_q <= cpu.memwrite;
         end
      end
   end

   // Combinational strobes are gated by reset so an abort takes effect at once.
   assign sram_ren_o   = go & ~reset;
   assign sram_wen_o   = (state_q == ST_WR) & ~reset;
   assign sram_addr_o  = (state_q == ST_IDLE) ? cpu.addr[ADDR_WIDTH+1:2] : waddr_q;
   assign sram_wdata_o = merged_q;

   assign cpu.stall      = ~reset & (go | (state_q == ST_RD) | (state_q == ST_WR));
   assign cpu.read_data  = read_data_q;
   assign cpu.misaligned = misaligned_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_data_mem_ctrl;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] sram_addr;
   logic          sram_ren;
   logic          sram_wen;
   logic [31:0]   sram_wdata;
   logic [31:0]   sram_rdata = '0;
   logic [31:0]   mem [0:(1<<AW)-1];
   int            wen_count = 0;
   int            vec_count = 0;
   int            miscompares = 0;

   data_mem_ctrl_if cpu_if ();

   data_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .cpu          (cpu_if.slave),
      .sram_addr_o  (sram_addr),
      .sram_ren_o   (sram_ren),
      .sram_wen_o   (sram_wen),
      .sram_wdata_o (sram_wdata),
      .sram_rdata_i (sram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sram_wen) begin
         mem[sram_addr] <= sram_wdata;
         wen_count++;
      end
      if (sram_ren)
         sram_rdata <= mem[sram_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_count++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Presents a request, samples stall/strobes each cycle until stall drops,
   // holds the request through DONE, then releases it.
   task automatic do_access(input logic wr, input logic rd, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] m,
                            output int nstall, output int nwen, output int nren);
      bit finished = 1'b0;
      @(negedge clk);
      cpu_if.memwrite   = wr;
      cpu_if.memread    = rd;
      cpu_if.addr       = a;
      cpu_if.write_data = wd;
      cpu_if.sign_mask  = m;
      nstall = 0;
      nwen   = 0;
      nren   = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (sram_wen) nwen++;
         if (sram_ren) nren++;
         if (!cpu_if.stall) begin
            finished = 1'b1;
            break;
         end
         nstall++;
         @(negedge clk);
      end
      if (!finished) check("stall_timeout", 32'd0, 32'd1);
      @(negedge clk);
      cpu_if.memwrite = 1'b0;
      cpu_if.memread  = 1'b0;
      #1;
   endtask

   int ns, nw, nr, wen_before;

   initial begin
      cpu_if.memwrite   = 1'b0;
      cpu_if.memread    = 1'b0;
      cpu_if.addr       = '0;
      cpu_if.write_data = '0;
      cpu_if.sign_mask  = '0;
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_stall", {31'd0, cpu_if.stall}, 32'd0);
      check("rst_read_data", cpu_if.read_data, 32'd0);
      check("rst_misaligned", {31'd0, cpu_if.misaligned}, 32'd0);
      check("rst_ren", {31'd0, sram_ren}, 32'd0);
      check("rst_wen", {31'd0, sram_wen}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Word store then load
      do_access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'b0111, ns, nw, nr);
      check("sw_stall_len", ns, 3);
      check("sw_wen_cycles", nw, 1);
      check("sw_ren_cycles", nr, 1);
      check("sw_sram_word", mem[4], 32'hDEADBEEF);
      do_access(1'b0, 1'b1, 32'h10, 32'h0, 4'b0111, ns, nw, nr);
      check("lw_stall_len", ns, 2);
      check("lw_wen_cycles", nw, 0);
      check("lw_data", cpu_if.read_data, 32'hDEADBEEF);

      // Byte store read-modify-write
      mem[8] = 32'h11223344;
      do_access(1'b1, 1'b0, 32'h22, 32'h000000AA, 4'b0001, ns, nw, nr);
      check("sb_stall_len", ns, 3);
      check("sb_rmw_word", mem[8], 32'h11AA3344);

      // Signed and unsigned sub-word loads
      mem[12] = 32'h000080FF;
      mem[13] = 32'h80017F02;
      do_access(1'b0, 1'b1, 32'h30, 32'h0, 4'b1001, ns, nw, nr);
      check("lb_30", cpu_if.read_data, 32'hFFFFFFFF);
      do_access(1'b0, 1'b1, 32'h31, 32'h0, 4'b0001, ns, nw, nr);
      check("lbu_31", cpu_if.read_data, 32'h00000080);
      do_access(1'b0, 1'b1, 32'h30, 32'h0, 4'b1011, ns, nw, nr);
      check("lh_30", cpu_if.read_data, 32'hFFFF80FF);
      do_access(1'b0, 1'b1, 32'h36, 32'h0, 4'b1011, ns, nw, nr);
      check("lh_36", cpu_if.read_data, 32'hFFFF8001);
      do_access(1'b0, 1'b1, 32'h34, 32'h0, 4'b0011, ns, nw, nr);
      check("lhu_34", cpu_if.read_data, 32'h00007F02);
      do_access(1'b0, 1'b1, 32'h35, 32'h0, 4'b1001, ns, nw, nr);
      check("lb_35", cpu_if.read_data, 32'h0000007F);
      do_access(1'b0, 1'b1, 32'h37, 32'h0, 4'b0001, ns, nw, nr);
      check("lbu_37", cpu_if.read_data, 32'h00000080);
      do_access(1'b0, 1'b1, 32'h34, 32'h0, 4'b0010, ns, nw, nr);
      check("odd_size_as_word", cpu_if.read_data, 32'h80017F02);

      // Misaligned word load and half store
      do_access(1'b0, 1'b1, 32'h13, 32'h0, 4'b0111, ns, nw, nr);
      check("mis_lw_stall", ns, 0);
      check("mis_lw_ren", nr, 0);
      check("mis_lw_pulse", {31'd0, cpu_if.misaligned}, 32'd1);
      check("mis_lw_read_data", cpu_if.read_data, 32'h80017F02);
      @(negedge clk);
      #1;
      check("mis_lw_pulse_end", {31'd0, cpu_if.misaligned}, 32'd0);
      wen_before = wen_count;
      do_access(1'b1, 1'b0, 32'h21, 32'h00005566, 4'b0011, ns, nw, nr);
      check("mis_sh_stall", ns, 0);
      check("mis_sh_ren", nr, 0);
      check("mis_sh_pulse", {31'd0, cpu_if.misaligned}, 32'd1);
      repeat (2) @(negedge clk);
      check("mis_sh_no_write", wen_count - wen_before, 0);
      check("mis_sh_sram_word", mem[8], 32'h11AA3344);

      // Store priority when both strobes set, then back-to-back load
      do_access(1'b1, 1'b1, 32'h50, 32'hCAFEF00D, 4'b0111, ns, nw, nr);
      check("both_stall_len", ns, 3);
      check("both_wen_cycles", nw, 1);
      check("both_no_reissue", nr, 1);
      do_access(1'b0, 1'b1, 32'h50, 32'h0, 4'b0111, ns, nw, nr);
      check("b2b_lw_data", cpu_if.read_data, 32'hCAFEF00D);
      check("b2b_no_reissue", nr, 1);

      // Reset during the read phase of a byte store
      mem[16] = 32'h55667788;
      wen_before = wen_count;
      @(negedge clk);
      cpu_if.memwrite   = 1'b1;
      cpu_if.addr       = 32'h40;
      cpu_if.write_data = 32'h00000099;
      cpu_if.sign_mask  = 4'b0001;
      @(negedge clk);
      #1;
      check("rst_mid_in_rd_stall", {31'd0, cpu_if.stall}, 32'd1);
      reset = 1'b1;
      #1;
      check("rst_mid_stall", {31'd0, cpu_if.stall}, 32'd0);
      check("rst_mid_read_data", cpu_if.read_data, 32'd0);
      check("rst_mid_wen", {31'd0, sram_wen}, 32'd0);
      cpu_if.memwrite = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_no_write", wen_count - wen_before, 0);
      check("rst_mid_sram_word", mem[16], 32'h55667788);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
